// File: rtl/timer_regressivo_if.sv
// Button/preset inputs and display/status outputs of the countdown timer.
// The master drives the buttons and preset; the timer is the slave.
interface timer_regressivo_if;
    logic        start_n;
    logic        load_n;
    logic [15:0] preset;
    logic [6:0]  disp1;
    logic [6:0]  disp2;
    logic [6:0]  disp3;
    logic [6:0]  disp4;
    logic        running;
    logic        alarm;

    modport master (
        output start_n, load_n, preset,
        input  disp1, disp2, disp3, disp4, running, alarm
    );

    modport slave (
        input  start_n, load_n, preset,
        output disp1, disp2, disp3, disp4, running, alarm
    );
endinterface

// File: rtl/timer_regressivo.sv
// MM:SS countdown timer with sampled-button debounce, BCD preset clamp and latched alarm.
// Segment outputs are active-high {g,f,e,d,c,b,a}.
module timer_regressivo #(
    parameter int TICKS_PER_SEC  = 5000,
    parameter int DEBOUNCE_TICKS = 2500
) (
    input  logic               clkin,
    input  logic               reset,
    timer_regressivo_if.slave  bus
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(TICKS_PER_SEC - 1);
    localparam logic [DW-1:0] DB_TC    = DW'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_e;

    typedef struct packed {
        logic [3:0] dm;
        logic [3:0] um;
        logic [3:0] ds;
        logic [3:0] us;
    } digits_t;

    state_e        state_q, state_d;
    digits_t       digits_q, digits_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] db_cnt_q;
    logic          start_s_q, load_s_q;
    logic          running_q, alarm_q;

    logic          db_tc;
    logic          start_ev;
    logic          load_ev;
    digits_t       preset_clamped;
    digits_t       digits_dec;

    function automatic digits_t clamp_preset(logic [15:0] p);
        digits_t r;
        r.dm = (p[15:12] > 4'd5) ? 4'd5 : p[15:12];
        r.um = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
        r.ds = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
        r.us = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
        return r;
    endfunction

    // One-second BCD decrement; a zero digit wraps to its maximum and borrows upward.
    function automatic digits_t bcd_dec(digits_t d);
        digits_t r;
        r = d;
        if (d.us != 4'd0) begin
            r.us = d.us - 4'd1;
        end else begin
            r.us = 4'd9;
            if (d.ds != 4'd0) begin
                r.ds = d.ds - 4'd1;
            end else begin
                r.ds = 4'd5;
                if (d.um != 4'd0) begin
                    r.um = d.um - 4'd1;
                end else begin
                    r.um = 4'd9;
                    r.dm = d.dm - 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] sevenseg(logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            db_cnt_q  <= '0;
            start_s_q <= 1'b1;
            load_s_q  <= 1'b1;
        end else if (db_tc) begin
            db_cnt_q  <= '0;
            start_s_q <= bus.start_n;
            load_s_q  <= bus.load_n;
        end else begin
            db_cnt_q  <= db_cnt_q + DW'(1);
        end
    end

    // Press events fire on the sample cycle itself; load wins over a simultaneous start.
    assign db_tc    = (db_cnt_q == DB_TC);
    assign load_ev  = db_tc & load_s_q & ~bus.load_n;
    assign start_ev = db_tc & start_s_q & ~bus.start_n & ~load_ev;

    assign preset_clamped = clamp_preset(bus.preset);
    assign digits_dec     = bcd_dec(digits_q);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        digits_d = digits_q;
        presc_d  = presc_q;
        case (state_q)
            IDLE: begin
                if (load_ev) begin
                    digits_d = preset_clamped;
                    presc_d  = '0;
                end else if (start_ev && (digits_q != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (start_ev) begin
                    state_d = PAUSE;
                end else if (presc_q == PRESC_TC) begin
                    presc_d  = '0;
                    digits_d = digits_dec;
                    if (digits_dec == '0) state_d = ALARM;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            PAUSE, ALARM: begin
                if (load_ev) begin
                    digits_d = preset_clamped;
                    presc_d  = '0;
                    state_d  = IDLE;
                end else if (start_ev) begin
                    state_d = (state_q == PAUSE) ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            digits_q  <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            presc_q   <= presc_d;
            running_q <= (state_d == RUN);
            alarm_q   <= (state_d == ALARM);
        end
    end

    assign bus.disp1   = sevenseg(digits_q.us);
    assign bus.disp2   = sevenseg(digits_q.ds);
    assign bus.disp3   = sevenseg(digits_q.um);
    assign bus.disp4   = sevenseg(digits_q.dm);
    assign bus.running = running_q;
    assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_timer_regressivo.sv
// Bench for timer_regressivo: directed steps then random button traffic, every cycle
// compared with a seconds-based reference model plus fixed expected display values.
module tb_timer_regressivo;

    localparam int T  = 4;
    localparam int DB = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_regressivo_if bus_if ();

    timer_regressivo #(.TICKS_PER_SEC(T), .DEBOUNCE_TICKS(DB)) dut (
        .clkin (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    int    total = 0;
    int    bad   = 0;
    string phase = "reset";

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_ALARM} mode_e;
    mode_e m_mode;
    int    m_secs;
    int    m_frac;
    int    m_cyc;
    logic  m_s_prev;
    logic  m_l_prev;

    function automatic int clamp_secs(logic [15:0] p);
        int dm, um, ds, us;
        dm = (p[15:12] > 5) ? 5 : int'(p[15:12]);
        um = (p[11:8]  > 9) ? 9 : int'(p[11:8]);
        ds = (p[7:4]   > 5) ? 5 : int'(p[7:4]);
        us = (p[3:0]   > 9) ? 9 : int'(p[3:0]);
        return (dm * 10 + um) * 60 + ds * 10 + us;
    endfunction

    function automatic logic [6:0] seg(int d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return tbl[d];
    endfunction

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_secs   = 0;
        m_frac   = 0;
        m_cyc    = 0;
        m_s_prev = 1'b1;
        m_l_prev = 1'b1;
    endtask

    // Called at each rising edge, before the bench changes any input.
    task automatic model_step();
        bit sp, lp;
        sp = 0;
        lp = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_cyc % DB == DB - 1) begin
            sp = m_s_prev && !bus_if.start_n;
            lp = m_l_prev && !bus_if.load_n;
            m_s_prev = bus_if.start_n;
            m_l_prev = bus_if.load_n;
        end
        m_cyc++;
        if (lp) sp = 0;
        case (m_mode)
            M_IDLE: begin
                if (lp) begin
                    m_secs = clamp_secs(bus_if.preset);
                    m_frac = 0;
                end else if (sp && m_secs != 0) begin
                    m_mode = M_RUN;
                end
            end
            M_RUN: begin
                if (sp) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_frac++;
                    if (m_frac == T) begin
                        m_frac = 0;
                        m_secs--;
                        if (m_secs == 0) m_mode = M_ALARM;
                    end
                end
            end
            default: begin
                if (lp) begin
                    m_secs = clamp_secs(bus_if.preset);
                    m_frac = 0;
                    m_mode = M_IDLE;
                end else if (sp) begin
                    m_mode = (m_mode == M_PAUSE) ? M_RUN : M_IDLE;
                end
            end
        endcase
    endtask

    function automatic logic [29:0] observed();
        return {bus_if.disp4, bus_if.disp3, bus_if.disp2, bus_if.disp1,
                bus_if.running, bus_if.alarm};
    endfunction

    task automatic check(input string tag);
        logic [29:0] obs, exp;
        int mm, ss;
        mm  = m_secs / 60;
        ss  = m_secs % 60;
        exp = {seg(mm / 10), seg(mm % 10), seg(ss / 10), seg(ss % 10),
               m_mode == M_RUN, m_mode == M_ALARM};
        obs = observed();
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_const(input string tag, input logic [15:0] bcd,
                               input logic run, input logic alm);
        logic [29:0] obs, exp;
        exp = {seg(int'(bcd[15:12])), seg(int'(bcd[11:8])), seg(int'(bcd[7:4])),
               seg(int'(bcd[3:0])), run, alm};
        obs = observed();
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            check(phase);
        end
    endtask

    task automatic press_start();
        bus_if.start_n = 1'b0;
        tick(2 * DB);
        bus_if.start_n = 1'b1;
        tick(2 * DB);
    endtask

    task automatic press_load();
        bus_if.load_n = 1'b0;
        tick(2 * DB);
        bus_if.load_n = 1'b1;
        tick(2 * DB);
    endtask

    task automatic press_both();
        bus_if.start_n = 1'b0;
        bus_if.load_n  = 1'b0;
        tick(2 * DB);
        bus_if.start_n = 1'b1;
        bus_if.load_n  = 1'b1;
        tick(2 * DB);
    endtask

    initial begin
        rst            = 1'b1;
        bus_if.start_n = 1'b1;
        bus_if.load_n  = 1'b1;
        bus_if.preset  = 16'h0000;
        model_reset();
        tick(2);
        check_const("reset_state", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        tick(3);

        phase = "load_count";
        bus_if.preset = 16'h0012;
        press_load();
        check_const("loaded_0012", 16'h0012, 1'b0, 1'b0);
        press_start();
        tick(12 * T);
        check_const("alarm_at_zero", 16'h0000, 1'b0, 1'b1);

        phase = "alarm_exit";
        press_start();
        check_const("alarm_to_idle", 16'h0000, 1'b0, 1'b0);
        phase = "start_at_zero";
        press_start();
        check_const("idle_zero_ignored", 16'h0000, 1'b0, 1'b0);

        phase = "minute_borrow";
        bus_if.preset = 16'h0100;
        press_load();
        check_const("loaded_0100", 16'h0100, 1'b0, 1'b0);
        press_start();
        tick(2 * T);
        press_start();
        press_load();
        check_const("pause_load_0100", 16'h0100, 1'b0, 1'b0);

        phase = "clamp";
        bus_if.preset = 16'hFA7C;
        press_load();
        check_const("clamp_5959", 16'h5959, 1'b0, 1'b0);
        press_start();
        tick(T);

        phase = "pause_resume";
        press_start();
        tick(20);
        press_start();
        tick(3 * T);

        phase = "hold_start";
        bus_if.start_n = 1'b0;
        tick(50);
        bus_if.start_n = 1'b1;
        tick(4);

        phase = "both_in_pause";
        bus_if.preset = 16'h0234;
        press_both();
        check_const("both_pause_loaded", 16'h0234, 1'b0, 1'b0);

        phase = "async_reset";
        bus_if.preset = 16'h0327;
        press_load();
        bus_if.start_n = 1'b0;
        tick(DB);
        check_const("run_0327", 16'h0327, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_const("async_reset_clear", 16'h0000, 1'b0, 1'b0);
        bus_if.start_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);

        phase = "random";
        for (int i = 0; i < 200; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 2) begin
                press_start();
            end else if (r <= 4) begin
                if ($urandom_range(0, 1) == 0)
                    bus_if.preset = 16'($urandom);
                else
                    bus_if.preset = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
                press_load();
            end else if (r == 5) begin
                press_both();
            end else begin
                tick(int'($urandom_range(1, 12)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
